// File: rtl/cam_dvp_tx_if.sv
// Byte-stream input and DVP output bundle for the camera transmit path.
// The master side feeds bytes and observes the regenerated sensor timing.
interface cam_dvp_tx_if #(
    parameter int unsigned DSIZE = 8
);
    logic [DSIZE-1:0] in_data;
    logic             in_vld;
    logic             in_sof;
    logic             in_eof;
    logic             in_rdy;
    logic [DSIZE-1:0] dvp_data;
    logic             dvp_href;
    logic             dvp_vsync;

    modport master (
        output in_data, in_vld, in_sof, in_eof,
        input  in_rdy, dvp_data, dvp_href, dvp_vsync
    );

    modport slave (
        input  in_data, in_vld, in_sof, in_eof,
        output in_rdy, dvp_data, dvp_href, dvp_vsync
    );
endinterface

// File: rtl/cam_dvp_tx.sv
// DVP sensor emulator: turns a sof/eof-framed byte stream into vsync/href/data
// timing with programmable blanking; starvation and framing faults are flagged.
module cam_dvp_tx #(
    parameter int unsigned DSIZE      = 8,
    parameter int unsigned LINE_BYTES = 1280,
    parameter int unsigned LINES      = 400,
    parameter int unsigned VSYNC_CYC  = 16,
    parameter int unsigned VFP_CYC    = 32,
    parameter int unsigned HBLANK_CYC = 64,
    parameter int unsigned VBP_CYC    = 32
) (
    input  logic           cam_clk,
    input  logic           cam_rst_n,
    input  logic           en,
    input  logic           clr_err,
    output logic           busy,
    output logic           underrun,
    output logic           sync_err,
    cam_dvp_tx_if.slave    s
);
    typedef enum logic [2:0] {StIdle, StVsync, StVfp, StLine, StHblank, StVbp} state_e;

    localparam logic [15:0] VsyncLast  = 16'(VSYNC_CYC - 1);
    localparam logic [15:0] VfpLast    = 16'(VFP_CYC - 1);
    localparam logic [15:0] HblankLast = 16'(HBLANK_CYC - 1);
    localparam logic [15:0] VbpLast    = 16'(VBP_CYC - 1);
    localparam logic [11:0] ByteLast   = 12'(LINE_BYTES - 1);
    localparam logic [10:0] LineLast   = 11'(LINES - 1);
    localparam logic [23:0] LastPos    = 24'(LINE_BYTES * LINES - 1);

    state_e            state_q, state_d;
    logic [11:0]       byte_cnt_q, byte_cnt_d;
    logic [10:0]       line_cnt_q, line_cnt_d;
    logic [15:0]       blank_cnt_q, blank_cnt_d;
    logic [DSIZE-1:0]  dvp_data_q, dvp_data_d;
    logic              dvp_href_q, dvp_href_d;
    logic              dvp_vsync_q, dvp_vsync_d;
    logic              underrun_q, underrun_d;
    logic              sync_err_q, sync_err_d;
    logic              in_rdy;
    logic              in_line;
    logic [23:0]       fpos;
    logic              sync_set;

    always_ff @(posedge cam_clk or negedge cam_rst_n) begin
        if (!cam_rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            line_cnt_q  <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            line_cnt_q  <= line_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        line_cnt_d  = line_cnt_q;
        blank_cnt_d = blank_cnt_q + 16'd1;
        unique case (state_q)
            StIdle: begin
                blank_cnt_d = '0;
                byte_cnt_d  = '0;
                line_cnt_d  = '0;
                // The SOF byte stays on the bus so LINE consumes it as byte 0.
                if (en && s.in_vld && s.in_sof) state_d = StVsync;
            end
            StVsync: begin
                if (blank_cnt_q == VsyncLast) begin
                    state_d     = StVfp;
                    blank_cnt_d = '0;
                end
            end
            StVfp: begin
                if (blank_cnt_q == VfpLast) begin
                    state_d     = StLine;
                    blank_cnt_d = '0;
                    byte_cnt_d  = '0;
                end
            end
            StLine: begin
                blank_cnt_d = '0;
                byte_cnt_d  = byte_cnt_q + 12'd1;
                if (byte_cnt_q == ByteLast) begin
                    byte_cnt_d = '0;
                    line_cnt_d = line_cnt_q + 11'd1;
                    state_d    = (line_cnt_q == LineLast) ? StVbp : StHblank;
                end
            end
            StHblank: begin
                if (blank_cnt_q == HblankLast) begin
                    state_d     = StLine;
                    blank_cnt_d = '0;
                    byte_cnt_d  = '0;
                end
            end
            StVbp: begin
                if (blank_cnt_q == VbpLast) begin
                    state_d     = StIdle;
                    blank_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_line     = (state_q == StLine);
        busy        = (state_q != StIdle);
        in_rdy      = in_line || ((state_q == StIdle) && s.in_vld && !s.in_sof);
        fpos        = 24'(line_cnt_q) * 24'(LINE_BYTES) + 24'(byte_cnt_q);
        sync_set    = in_line && s.in_vld &&
                      ((s.in_sof && (fpos != 24'd0)) ||
                       (s.in_eof && (fpos != LastPos)) ||
                       (!s.in_eof && (fpos == LastPos)));
        dvp_href_d  = in_line;
        dvp_vsync_d = (state_q == StVsync);
        dvp_data_d  = (in_line && s.in_vld) ? s.in_data : '0;
        // A new error event outranks a same-cycle clear.
        underrun_d  = (in_line && !s.in_vld) || (underrun_q && !clr_err);
        sync_err_d  = sync_set || (sync_err_q && !clr_err);
    end

    always_ff @(posedge cam_clk or negedge cam_rst_n) begin
        if (!cam_rst_n) begin
            dvp_data_q  <= '0;
            dvp_href_q  <= 1'b0;
            dvp_vsync_q <= 1'b0;
            underrun_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            dvp_data_q  <= dvp_data_d;
            dvp_href_q  <= dvp_href_d;
            dvp_vsync_q <= dvp_vsync_d;
            underrun_q  <= underrun_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign s.in_rdy    = in_rdy;
    assign s.dvp_data  = dvp_data_q;
    assign s.dvp_href  = dvp_href_q;
    assign s.dvp_vsync = dvp_vsync_q;
    assign underrun    = underrun_q;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed bench for cam_dvp_tx with a 4-byte x 2-line frame geometry.
module tb_cam_dvp_tx;
    logic cam_clk;
    logic cam_rst_n;
    logic en;
    logic clr_err;
    logic busy;
    logic underrun;
    logic sync_err;

    cam_dvp_tx_if #(.DSIZE(8)) bus ();

    cam_dvp_tx #(
        .DSIZE(8), .LINE_BYTES(4), .LINES(2), .VSYNC_CYC(2),
        .VFP_CYC(3), .HBLANK_CYC(2), .VBP_CYC(3)
    ) dut (
        .cam_clk   (cam_clk),
        .cam_rst_n (cam_rst_n),
        .en        (en),
        .clr_err   (clr_err),
        .busy      (busy),
        .underrun  (underrun),
        .sync_err  (sync_err),
        .s         (bus.slave)
    );

    initial cam_clk = 1'b0;
    always #5 cam_clk = ~cam_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qd[$];
    bit         qs[$];
    bit         qe[$];
    int         idx;
    bit         drop_en   = 1'b0;
    bit         dropped   = 1'b0;
    int         en_off_at = -1;

    logic       lv[64], lh[64], lb[64], lu[64], ls[64], lr[64];
    logic [7:0] ld[64];

    task automatic load_frame(input bit eof_at_6, input bit resync);
        qd.delete(); qs.delete(); qe.delete();
        if (resync) begin
            qd.push_back(8'hAA); qs.push_back(1'b0); qe.push_back(1'b0);
            qd.push_back(8'hBB); qs.push_back(1'b0); qe.push_back(1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            qd.push_back(8'(8'h10 + i));
            qs.push_back(i == 0);
            qe.push_back(eof_at_6 ? (i == 6) : (i == 7));
        end
        idx = 0;
    endtask

    // One iteration per clock: drive, sample at negedge, advance on accept.
    task automatic run(input int n);
        bit acc;
        bit drop;
        for (int c = 0; c < n; c++) begin
            if (c == en_off_at) en = 1'b0;
            drop = drop_en && !dropped && (idx == 1);
            if ((idx < qd.size()) && !drop) begin
                bus.in_vld  = 1'b1;
                bus.in_data = qd[idx];
                bus.in_sof  = qs[idx];
                bus.in_eof  = qe[idx];
            end else begin
                bus.in_vld  = 1'b0;
                bus.in_data = 8'h00;
                bus.in_sof  = 1'b0;
                bus.in_eof  = 1'b0;
            end
            @(negedge cam_clk);
            lv[c] = bus.dvp_vsync;
            lh[c] = bus.dvp_href;
            ld[c] = bus.dvp_data;
            lb[c] = busy;
            lu[c] = underrun;
            ls[c] = sync_err;
            lr[c] = bus.in_rdy;
            acc = bus.in_vld && bus.in_rdy;
            @(posedge cam_clk);
            if (acc) idx++;
            if (drop) dropped = 1'b1;
            #1;
        end
        bus.in_vld = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_eof = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge cam_clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_vld  = 1'b1;
        bus.in_sof  = 1'b0;
        bus.in_data = 8'h55;
        #1;
        n_tests++;
        if ({bus.dvp_href, bus.dvp_vsync, busy, underrun, sync_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.dvp_href, bus.dvp_vsync, busy, underrun, sync_err});
        end
        n_tests++;
        if (bus.dvp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 00", bus.dvp_data);
        end
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_rdy got %b exp 1", bus.in_rdy);
        end
        bus.in_vld = 1'b0;
    endtask

    task automatic test_nominal();
        logic       ev, eh, eb;
        logic [7:0] ed;
        load_frame(1'b0, 1'b0);
        en = 1'b1;
        run(22);
        for (int c = 0; c < 22; c++) begin
            ev = (c == 2) || (c == 3);
            eh = (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
            eb = (c >= 1 && c <= 18);
            ed = (c >= 7 && c <= 10) ? 8'(8'h10 + c - 7) :
                 (c >= 13 && c <= 16) ? 8'(8'h14 + c - 13) : 8'h00;
            n_tests++;
            if ({lv[c], lh[c], lb[c]} !== {ev, eh, eb}) begin
                n_fail++;
                $display("FAIL nominal_timing c=%0d got vs/href/busy=%b exp %b",
                         c, {lv[c], lh[c], lb[c]}, {ev, eh, eb});
            end
            n_tests++;
            if (ld[c] !== ed) begin
                n_fail++;
                $display("FAIL nominal_data c=%0d got %h exp %h", c, ld[c], ed);
            end
        end
        n_tests++;
        if ({lu[21], ls[21]} !== 2'b00) begin
            n_fail++;
            $display("FAIL nominal_errors got %b exp 00", {lu[21], ls[21]});
        end
    endtask

    task automatic test_resync();
        load_frame(1'b0, 1'b1);
        run(24);
        n_tests++;
        if ({lr[0], lr[1]} !== 2'b11) begin
            n_fail++;
            $display("FAIL resync_discard_rdy got %b exp 11", {lr[0], lr[1]});
        end
        n_tests++;
        if ({lh[8], lh[9]} !== 2'b01) begin
            n_fail++;
            $display("FAIL resync_href_start got %b exp 01", {lh[8], lh[9]});
        end
        for (int c = 9; c <= 12; c++) begin
            n_tests++;
            if (ld[c] !== 8'(8'h10 + c - 9)) begin
                n_fail++;
                $display("FAIL resync_data c=%0d got %h exp %h", c, ld[c], 8'(8'h10 + c - 9));
            end
        end
        n_tests++;
        if (idx !== 10) begin
            n_fail++;
            $display("FAIL resync_consumed got %0d exp 10", idx);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] exp_d[4];
        exp_d[0] = 8'h10; exp_d[1] = 8'h00; exp_d[2] = 8'h11; exp_d[3] = 8'h12;
        load_frame(1'b0, 1'b0);
        drop_en = 1'b1;
        dropped = 1'b0;
        run(22);
        drop_en = 1'b0;
        for (int c = 7; c <= 10; c++) begin
            n_tests++;
            if ({lh[c], ld[c]} !== {1'b1, exp_d[c-7]}) begin
                n_fail++;
                $display("FAIL underrun_line0 c=%0d got href=%b data=%h exp href=1 data=%h",
                         c, lh[c], ld[c], exp_d[c-7]);
            end
        end
        n_tests++;
        if ({lu[7], lu[8], lu[21]} !== 3'b011) begin
            n_fail++;
            $display("FAIL underrun_flag got %b exp 011", {lu[7], lu[8], lu[21]});
        end
        n_tests++;
        if (ls[21] !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_shift_sync got %b exp 1", ls[21]);
        end
        pulse_clr();
        n_tests++;
        if ({underrun, sync_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL underrun_clr got %b exp 00", {underrun, sync_err});
        end
    endtask

    task automatic test_bad_eof();
        int hc;
        load_frame(1'b1, 1'b0);
        run(22);
        hc = 0;
        for (int c = 0; c < 22; c++) if (lh[c] === 1'b1) hc++;
        n_tests++;
        if (hc !== 8) begin
            n_fail++;
            $display("FAIL bad_eof_href_count got %0d exp 8", hc);
        end
        n_tests++;
        if ({ls[14], ls[15], ls[21]} !== 3'b011) begin
            n_fail++;
            $display("FAIL bad_eof_sync_err got %b exp 011", {ls[14], ls[15], ls[21]});
        end
        n_tests++;
        if (lu[21] !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_eof_underrun got %b exp 0", lu[21]);
        end
        pulse_clr();
        n_tests++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_eof_clr got %b exp 0", sync_err);
        end
    endtask

    task automatic test_en_low();
        int hc;
        int vc;
        int bc;
        load_frame(1'b0, 1'b0);
        en = 1'b1;
        en_off_at = 4;
        run(22);
        en_off_at = -1;
        hc = 0;
        for (int c = 0; c < 22; c++) if (lh[c] === 1'b1) hc++;
        n_tests++;
        if ({hc, lb[18], lb[19], ld[16]} !== {8, 1'b1, 1'b0, 8'h17}) begin
            n_fail++;
            $display("FAIL en_low_completes got href=%0d busy18=%b busy19=%b d16=%h exp 8 1 0 17",
                     hc, lb[18], lb[19], ld[16]);
        end
        load_frame(1'b0, 1'b0);
        run(10);
        vc = 0;
        bc = 0;
        for (int c = 0; c < 10; c++) begin
            if (lv[c] !== 1'b0) vc++;
            if (lb[c] !== 1'b0) bc++;
        end
        n_tests++;
        if ({vc, bc} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL en_low_blocked got vsync_cycles=%0d busy_cycles=%0d exp 0 0", vc, bc);
        end
        n_tests++;
        if ({lr[0], idx} !== {1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL en_low_sof_held got rdy=%b consumed=%0d exp 0 0", lr[0], idx);
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        load_frame(1'b0, 1'b0);
        run(14);
        n_tests++;
        if ({bus.dvp_href, bus.dvp_data} !== {1'b1, 8'h15}) begin
            n_fail++;
            $display("FAIL rst_mid_pre got href=%b data=%h exp 1 15", bus.dvp_href, bus.dvp_data);
        end
        #2;
        cam_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.dvp_href, bus.dvp_vsync, busy, bus.dvp_data} !== 11'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async got href=%b vsync=%b busy=%b data=%h exp 0 0 0 00",
                     bus.dvp_href, bus.dvp_vsync, busy, bus.dvp_data);
        end
        repeat (2) @(posedge cam_clk);
        #1;
        cam_rst_n = 1'b1;
        load_frame(1'b0, 1'b0);
        run(5);
        n_tests++;
        if ({lv[1], lv[2], lv[3], lv[4], lb[1]} !== 5'b01101) begin
            n_fail++;
            $display("FAIL rst_mid_restart got %b exp 01101", {lv[1], lv[2], lv[3], lv[4], lb[1]});
        end
    endtask

    initial begin
        cam_rst_n   = 1'b0;
        en          = 1'b0;
        clr_err     = 1'b0;
        bus.in_data = 8'h00;
        bus.in_vld  = 1'b0;
        bus.in_sof  = 1'b0;
        bus.in_eof  = 1'b0;
        @(posedge cam_clk);
        #1;
        test_reset();
        @(posedge cam_clk);
        #1;
        cam_rst_n = 1'b1;
        test_nominal();
        test_resync();
        test_underrun();
        test_bad_eof();
        test_en_low();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_dvp_tx.md
Name: cam_dvp_tx

Overview:
- Transmit side of the camera parallel (DVP) interface.
- Consumes a byte stream carrying start/end-of-frame sideband (valid/ready handshake) and regenerates sensor-style vsync/href/data timing with programmable blanking.
- Used as a sensor emulator for loopback and regression: its outputs drive the camera receive path in place of a real sensor, clocked on cam_clk.
- Line data cannot stall once href is high; upstream starvation is flagged, not absorbed.

Parameters:
- DSIZE, 8, data byte width.
- LINE_BYTES, 1280, bytes per line (href-high cycles), >=1, <=4095.
- LINES, 400, lines per frame, >=1, <=2047.
- VSYNC_CYC, 16, vsync pulse width in cycles, >=1.
- VFP_CYC, 32, cycles from vsync fall to first href, >=1.
- HBLANK_CYC, 64, href-low cycles between lines, >=1.
- VBP_CYC, 32, cycles after last line before return to IDLE, >=1.

Ports:
- cam_clk  in  1  sole clock.
- cam_rst_n  in  1  asynchronous active-low reset.
- en  in  1  enable frame generation; sampled only in IDLE.
- in_data  in  DSIZE  stream byte.
- in_vld  in  1  in_data/in_sof/in_eof valid.
- in_sof  in  1  first byte of frame.
- in_eof  in  1  last byte of frame.
- in_rdy  out  1  byte accepted when in_vld & in_rdy.
- dvp_data  out  DSIZE  parallel pixel byte.
- dvp_href  out  1  line-valid.
- dvp_vsync  out  1  frame sync, active high.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky: LINE cycle with in_vld=0.
- sync_err  out  1  sticky: sof/eof position mismatch.
- clr_err  in  1  synchronous clear of underrun and sync_err.

Behaviour:
- Reset: state=IDLE, all counters 0. dvp_data=0, dvp_href=0, dvp_vsync=0, underrun=0, sync_err=0, busy=0.
- dvp_* are registered from state. in_rdy is combinational from state.
- States: IDLE, VSYNC, VFP, LINE, HBLANK, VBP.
- IDLE:
  - in_rdy = in_vld & ~in_sof: non-SOF bytes are discarded for resync.
  - When en & in_vld & in_sof: go to VSYNC. The SOF byte is not consumed.
- VSYNC: VSYNC_CYC cycles, then VFP. dvp_vsync=1 on the cycles following each VSYNC-state cycle (one-cycle register lag).
- VFP: VFP_CYC cycles, then LINE. in_rdy=0.
- LINE:
  - Exactly LINE_BYTES cycles. in_rdy=1 every cycle.
  - Next cycle: dvp_href=1 and dvp_data = in_vld ? in_data : 0.
  - byte_cnt advances every LINE cycle whether or not in_vld is high.
  - After the last byte: line_cnt+1. If line_cnt==LINES-1, go to VBP; else go to HBLANK.
- HBLANK: HBLANK_CYC cycles, then LINE.
- VBP: VBP_CYC cycles, then IDLE.
- Outside LINE: dvp_href=0 and dvp_data=0, one cycle after leaving LINE.
- Frame position: fpos = line_cnt*LINE_BYTES + byte_cnt, evaluated on each accepted LINE byte.
  - sync_err sets if in_sof=1 at fpos!=0.
  - sync_err sets if in_eof=1 at fpos!=LINE_BYTES*LINES-1.
  - sync_err sets if in_eof=0 at the final position with in_vld=1.
  - Timing is unaffected; the frame always completes its full geometry.
- Underrun: LINE cycle with in_vld=0 sets underrun; the byte slot is emitted as 0.
- en deassert mid-frame: current frame completes through VBP; frame start is then blocked in IDLE.
- clr_err together with a new error event in the same cycle: the set wins.
- Async reset mid-frame: outputs drop to reset values immediately. A partial frame is abandoned.
- Counter widths: byte_cnt 12b, line_cnt 11b, blank_cnt 16b. Each counter resets to 0 on state entry.

Test Plan:
Bench parameters: LINE_BYTES=4, LINES=2, VSYNC_CYC=2, VFP_CYC=3, HBLANK_CYC=2, VBP_CYC=3.
- Nominal frame: en=1, continuous in_vld stream 0x10..0x17 with sof on 0x10 and eof on 0x17.
  - vsync high 2 cycles, then 3 low cycles.
  - href high 4 cycles with data 10,11,12,13, low 2, high 4 with data 14..17.
  - busy falls 3 cycles after the last href. Errors stay 0.
- Resync: bytes 0xAA,0xBB without sof precede the sof byte.
  - Both are consumed in IDLE (in_rdy=1). The frame starts with data 10.
- Underrun: in_vld dropped for the 2nd byte of line 0.
  - dvp_data = 10,00,11,12 on line 0; underrun=1 after that cycle.
  - clr_err clears it.
- Misaligned eof: in_eof on byte 6 (0x16).
  - sync_err=1, and the frame still emits 8 href cycles.
- en low mid-frame: frame completes. With a sof byte waiting and en low, the FSM stays in IDLE and vsync does not reassert.
- Reset mid-LINE: cam_rst_n low during line 1.
  - href, vsync and data go 0 asynchronously.
  - After release, the next sof starts a new VSYNC.
